// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command producer and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, done, ack_err, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, done, ack_err, timeout_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Define PS2_TX_ACK_CHECK_EN to report a device NACK on ack_err; otherwise the ACK bit is ignored.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave tx_if,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         ps2_clk_drv,
  output logic         ps2_data_drv
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    XFER,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       clk_sr;
  logic [7:0]       data_sr;
  logic             clk_f;
  logic             data_f;
  logic             clk_f_d;
  logic             clk_fall;
  logic             clk_edge;
  logic [8:0]       frame;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             accept;
  logic             to_run;
  logic             timed_out;
  logic             clk_drv;
  logic             data_drv;
  logic             ready;
  logic             done_p;
  logic             ack_err_p;
  logic             timeout_p;
`ifdef PS2_TX_ACK_CHECK_EN
  logic             ack_take;
  logic             ack_bad;
`endif

  // The filtered lines only move once eight consecutive samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sr  <= '1;
      data_sr <= '1;
      clk_f   <= 1'b1;
      data_f  <= 1'b1;
      clk_f_d <= 1'b1;
    end else begin
      clk_sr  <= {clk_sr[6:0], ps2_clk};
      data_sr <= {data_sr[6:0], ps2_data};
      if (clk_sr == 8'hFF)
        clk_f <= 1'b1;
      else if (clk_sr == 8'h00)
        clk_f <= 1'b0;
      if (data_sr == 8'hFF)
        data_f <= 1'b1;
      else if (data_sr == 8'h00)
        data_f <= 1'b0;
      clk_f_d <= clk_f;
    end
  end

  assign clk_fall  = clk_f_d & ~clk_f;
  assign clk_edge  = clk_f_d ^ clk_f;
  assign timed_out = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    clk_drv   = 1'b0;
    data_drv  = 1'b0;
    done_p    = 1'b0;
    ack_err_p = 1'b0;
    timeout_p = 1'b0;
    accept    = 1'b0;
    to_run    = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_take  = 1'b0;
`endif
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (tx_if.tx_valid) begin
          accept    = 1'b1;
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_drv = 1'b1;
        if (inh_cnt == INH_LAST) begin
          data_drv  = 1'b1;
          state_nxt = RTS;
        end
      end
      RTS: begin
        data_drv = 1'b1;
        to_run   = 1'b1;
        if (clk_fall)
          state_nxt = XFER;
      end
      XFER: begin
        data_drv = ~frame[bit_idx];
        to_run   = 1'b1;
        if (clk_fall && bit_idx == 4'd8)
          state_nxt = ACK;
      end
      ACK: begin
        to_run = 1'b1;
        if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          ack_take  = 1'b1;
`endif
          state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        to_run = 1'b1;
        if (clk_f && data_f) begin
`ifdef PS2_TX_ACK_CHECK_EN
          ack_err_p = ack_bad;
          done_p    = ~ack_bad;
`else
          done_p    = 1'b1;
`endif
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A stalled device wins over whatever the frame was about to do.
    if (to_run && timed_out) begin
      clk_drv   = 1'b0;
      data_drv  = 1'b0;
      done_p    = 1'b0;
      ack_err_p = 1'b0;
      timeout_p = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= '0;
      bit_idx <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_bad <= 1'b0;
`endif
    end else begin
      if (accept) begin
        frame   <= {~^tx_if.tx_data, tx_if.tx_data};
        bit_idx <= '0;
        inh_cnt <= '0;
      end else begin
        if (state == INHIBIT)
          inh_cnt <= inh_cnt + 1'b1;
        if (state == XFER && clk_fall && bit_idx != 4'd8)
          bit_idx <= bit_idx + 1'b1;
      end
      // INHIBIT is not a counting state, so the count is already zero on RTS entry.
      if (!to_run || clk_edge)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
      if (ack_take)
        ack_bad <= data_f;
`endif
    end
  end

  assign ps2_clk_drv       = clk_drv;
  assign ps2_data_drv      = data_drv;
  assign tx_if.tx_ready    = ready;
  assign tx_if.done        = done_p;
  assign tx_if.ack_err     = ack_err_p;
  assign tx_if.timeout_err = timeout_p;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 bus with a clocking device model and a frame reference.
module tb_ps2_host_tx;
  localparam int INH = 16;
  localparam int TO  = 1000;

`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_drv;
  logic ps2_data_drv;
  logic ps2_clk_line;
  logic ps2_data_line;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int to_cnt = 0;
  int excl_viol = 0;
  int frames = 0;
  int clk_run = 0;
  int last_run = 0;
  logic drv_d = 1'b0;

  ps2_host_tx_if tx_if ();

  assign ps2_clk_line  = ~(ps2_clk_drv | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_drv | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_if       (tx_if),
    .ps2_clk     (ps2_clk_line),
    .ps2_data    (ps2_data_line),
    .ps2_clk_drv (ps2_clk_drv),
    .ps2_data_drv(ps2_data_drv)
  );

  always #5 clk = ~clk;

  // Pulse tallies and the length of every host clock-inhibit window.
  always @(negedge clk) begin
    if (tx_if.done) done_cnt++;
    if (tx_if.ack_err) ack_cnt++;
    if (tx_if.timeout_err) to_cnt++;
    if (int'(tx_if.done) + int'(tx_if.ack_err) + int'(tx_if.timeout_err) > 1) excl_viol++;
    if (ps2_clk_drv) begin
      if (!drv_d) frames++;
      clk_run++;
    end else if (clk_run != 0) begin
      last_run = clk_run;
      clk_run  = 0;
    end
    drv_d = ps2_clk_drv;
  end

  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_byte(input logic [7:0] b, input bit hold);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'($urandom);
  endtask

  // Device side: waits for request-to-send, then clocks the frame (200-cycle period).
  task automatic device_frame(input bit ack_good, input int stop_after, input bit glitch,
                              output logic [10:0] cap, output bit ok);
    int n;
    cap = '0;
    ok  = 1'b1;
    n = 0;
    while (!ps2_clk_drv && n < 200) begin @(negedge clk); n++; end
    if (!ps2_clk_drv) ok = 1'b0;
    n = 0;
    while (ps2_clk_drv && n < 200) begin @(negedge clk); n++; end
    if (ps2_clk_drv) ok = 1'b0;
    if (!ok) return;
    repeat (20) @(negedge clk);
    cap[0] = ps2_data_line;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (k == stop_after) return;
      repeat (100) @(negedge clk);
      dev_clk_low = 1'b0;
      cap[k] = ps2_data_line;
      if (glitch && k >= 2 && k <= 8) begin
        int g;
        g = $urandom_range(1, 7);
        repeat (30) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (g) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (70 - g) @(negedge clk);
      end else begin
        repeat (100) @(negedge clk);
      end
    end
    dev_data_low = ack_good;
    repeat (50) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (100) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_pulse(input int bound, output int n);
    n = 0;
    while (!(tx_if.done || tx_if.ack_err || tx_if.timeout_err) && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (ps2_clk_drv !== 1'b0) begin fails++; $display("[TB] FAIL reset_clk_drv: got %b, expected 0", ps2_clk_drv); end
    tests++; if (ps2_data_drv !== 1'b0) begin fails++; $display("[TB] FAIL reset_data_drv: got %b, expected 0", ps2_data_drv); end
    tests++; if (tx_if.tx_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_tx_ready: got %b, expected 1", tx_if.tx_ready); end
    tests++; if ({tx_if.done, tx_if.ack_err, tx_if.timeout_err} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_pulses: got %b, expected 000", {tx_if.done, tx_if.ack_err, tx_if.timeout_err});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (tx_if.tx_ready !== 1'b1) begin fails++; $display("[TB] FAIL idle_tx_ready: got %b, expected 1", tx_if.tx_ready); end
  endtask

  task automatic test_basic();
    logic [7:0]  bytes [3] = '{8'hED, 8'h00, 8'h01};
    logic        par   [3] = '{1'b1, 1'b1, 1'b0};
    logic [10:0] cap;
    bit          ok;
    int          d0, a0;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt; a0 = ack_cnt;
      start_byte(bytes[i], 1'b0);
      device_frame(1'b1, 0, 1'b0, cap, ok);
      repeat (60) @(negedge clk);
      tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL basic_rts[%h]: got %b, expected 1", bytes[i], ok); end
      tests++; if (cap !== ref_frame(bytes[i])) begin fails++; $display("[TB] FAIL basic_frame[%h]: got %b, expected %b", bytes[i], cap, ref_frame(bytes[i])); end
      tests++; if (cap[9] !== par[i]) begin fails++; $display("[TB] FAIL basic_parity[%h]: got %b, expected %b", bytes[i], cap[9], par[i]); end
      tests++; if (last_run !== INH) begin fails++; $display("[TB] FAIL basic_inhibit[%h]: got %0d, expected %0d", bytes[i], last_run, INH); end
      tests++; if (done_cnt - d0 !== 1 || ack_cnt - a0 !== 0) begin
        fails++; $display("[TB] FAIL basic_pulses[%h]: got done %0d ack_err %0d, expected 1 0", bytes[i], done_cnt - d0, ack_cnt - a0);
      end
      tests++; if ({ps2_clk_drv, ps2_data_drv} !== 2'b00) begin fails++; $display("[TB] FAIL basic_release[%h]: got %b, expected 00", bytes[i], {ps2_clk_drv, ps2_data_drv}); end
    end
  endtask

  task automatic test_random_ack();
    logic [7:0]  b;
    bit          good;
    logic [10:0] cap;
    bit          ok;
    int          d0, a0, exp_d, exp_a;
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom);
      good = (i == 0) ? 1'b0 : 1'($urandom);
      exp_d = (good || !ACK_CHECK) ? 1 : 0;
      exp_a = 1 - exp_d;
      d0 = done_cnt; a0 = ack_cnt;
      start_byte(b, 1'b0);
      device_frame(good, 0, 1'b0, cap, ok);
      repeat (60) @(negedge clk);
      tests++; if (cap !== ref_frame(b) || !ok) begin fails++; $display("[TB] FAIL rand_frame[%h]: got %b, expected %b", b, cap, ref_frame(b)); end
      tests++; if (done_cnt - d0 !== exp_d || ack_cnt - a0 !== exp_a) begin
        fails++; $display("[TB] FAIL rand_ack[%h ack_good=%b]: got done %0d ack_err %0d, expected %0d %0d",
                          b, good, done_cnt - d0, ack_cnt - a0, exp_d, exp_a);
      end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] cap;
    bit          ok;
    int          n, d0, a0, t0;
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    start_byte(8'($urandom), 1'b0);
    device_frame(1'b1, 4, 1'b0, cap, ok);
    wait_pulse(TO + 200, n);
    tests++; if (tx_if.timeout_err !== 1'b1 || n < TO || n > TO + 30) begin
      fails++; $display("[TB] FAIL timeout_delay: got %0d cycles (pulse %b), expected %0d..%0d", n, tx_if.timeout_err, TO, TO + 30);
    end
    tests++; if ({ps2_clk_drv, ps2_data_drv} !== 2'b00) begin fails++; $display("[TB] FAIL timeout_release: got %b, expected 00", {ps2_clk_drv, ps2_data_drv}); end
    @(negedge clk);
    tests++; if (tx_if.tx_ready !== 1'b1) begin fails++; $display("[TB] FAIL timeout_ready: got %b, expected 1", tx_if.tx_ready); end
    dev_clk_low = 1'b0;
    repeat (30) @(negedge clk);
    tests++; if (to_cnt - t0 !== 1 || done_cnt - d0 !== 0 || ack_cnt - a0 !== 0) begin
      fails++; $display("[TB] FAIL timeout_pulses: got to %0d done %0d ack %0d, expected 1 0 0", to_cnt - t0, done_cnt - d0, ack_cnt - a0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] cap;
    bit          ok;
    int          d0, a0, t0;
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    start_byte(8'h00, 1'b0);
    device_frame(1'b1, 4, 1'b0, cap, ok);
    repeat (30) @(negedge clk);
    tests++; if (ps2_data_drv !== 1'b1) begin fails++; $display("[TB] FAIL mid_bit3_drv: got %b, expected 1", ps2_data_drv); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({ps2_clk_drv, ps2_data_drv} !== 2'b00) begin fails++; $display("[TB] FAIL mid_reset_release: got %b, expected 00", {ps2_clk_drv, ps2_data_drv}); end
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (done_cnt != d0 || ack_cnt != a0 || to_cnt != t0) begin
      fails++; $display("[TB] FAIL mid_reset_pulse: got %0d extra pulses, expected 0", (done_cnt - d0) + (ack_cnt - a0) + (to_cnt - t0));
    end
    start_byte(8'hF4, 1'b0);
    device_frame(1'b1, 0, 1'b0, cap, ok);
    repeat (60) @(negedge clk);
    tests++; if (cap !== ref_frame(8'hF4) || !ok) begin fails++; $display("[TB] FAIL after_reset_frame: got %b, expected %b", cap, ref_frame(8'hF4)); end
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("[TB] FAIL after_reset_done: got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_glitch_hold();
    logic [7:0]  b;
    logic [10:0] cap;
    bit          ok;
    int          n, d0, f0;
    b  = 8'($urandom);
    d0 = done_cnt; f0 = frames;
    start_byte(b, 1'b1);
    device_frame(1'b1, 0, 1'b1, cap, ok);
    wait_pulse(200, n);
    tx_if.tx_valid = 1'b0;
    tests++; if (tx_if.done !== 1'b1) begin fails++; $display("[TB] FAIL glitch_done: got %b, expected 1", tx_if.done); end
    repeat (60) @(negedge clk);
    tests++; if (cap !== ref_frame(b) || !ok) begin fails++; $display("[TB] FAIL glitch_frame[%h]: got %b, expected %b", b, cap, ref_frame(b)); end
    tests++; if (frames - f0 !== 1 || done_cnt - d0 !== 1) begin
      fails++; $display("[TB] FAIL hold_valid_once: got frames %0d done %0d, expected 1 1", frames - f0, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b1, b2;
    logic [10:0] cap;
    bit          ok;
    int          n, d0;
    b1 = 8'($urandom); b2 = 8'($urandom);
    d0 = done_cnt;
    start_byte(b1, 1'b0);
    device_frame(1'b1, 0, 1'b0, cap, ok);
    wait_pulse(200, n);
    tests++; if (tx_if.done !== 1'b1) begin fails++; $display("[TB] FAIL b2b_first_done: got %b, expected 1", tx_if.done); end
    tx_if.tx_data  = b2;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tests++; if (tx_if.tx_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready: got %b, expected 1", tx_if.tx_ready); end
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'($urandom);
    tests++; if (ps2_clk_drv !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept: got clk_drv %b, expected 1", ps2_clk_drv); end
    device_frame(1'b1, 0, 1'b0, cap, ok);
    repeat (60) @(negedge clk);
    tests++; if (cap !== ref_frame(b2) || !ok) begin fails++; $display("[TB] FAIL b2b_frame[%h]: got %b, expected %b", b2, cap, ref_frame(b2)); end
    tests++; if (done_cnt - d0 !== 2) begin fails++; $display("[TB] FAIL b2b_done: got %0d, expected 2", done_cnt - d0); end
  endtask

  task automatic test_exclusive();
    tests++; if (excl_viol !== 0) begin fails++; $display("[TB] FAIL pulse_exclusive: got %0d overlaps, expected 0", excl_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ack();
    test_timeout();
    test_reset_mid_frame();
    test_glitch_hold();
    test_back_to_back();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clk cycles the host holds ps2 clock low before the start bit (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, max clk cycles without a filtered ps2 clock edge before abort (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock; single clock domain, all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tx_data  input  8  command byte to send to the device.
REQ-006 tx_valid  input  1  request; the byte is accepted when tx_valid and tx_ready are both 1 on a clk edge.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk  input  1  raw PS/2 clock line (asynchronous).
REQ-009 ps2_data  input  1  raw PS/2 data line (asynchronous).
REQ-010 ps2_clk_drv  output  1  1 = pull ps2 clock low (open-drain enable); 0 = release.
REQ-011 ps2_data_drv  output  1  1 = pull ps2 data low; 0 = release.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 ack_err  output  1  one-cycle pulse when the device ACK bit is 1.
REQ-014 timeout_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 Inputs shall pass through an 8-sample shift filter; the filtered line changes only when all 8 samples agree (8'hFF -> 1, 8'h00 -> 0), otherwise holds.
REQ-016 A falling edge is filtered clock 1 in the previous cycle and 0 in the current cycle; all edge counting uses falling edges only.
REQ-017 States: IDLE, INHIBIT, RTS, XFER, ACK, WAIT_IDLE.
REQ-018 IDLE: both drivers 0, tx_ready 1; on accept latch tx_data, compute parity = ~^tx_data (odd), clear bit counter, go INHIBIT.
REQ-019 INHIBIT: ps2_clk_drv 1 for exactly INHIBIT_CYCLES cycles; ps2_data_drv goes 1 in the final INHIBIT cycle; then RTS.
REQ-020 RTS: ps2_clk_drv 0, ps2_data_drv 1 (start bit 0); on 1st falling edge drive data bit 0, go XFER.
REQ-021 XFER: on falling edges 2..8 drive data bits 1..7 (LSB first); on edge 9 drive parity; on edge 10 release data (stop = 1), go ACK; ps2_data_drv = ~(bit value).
REQ-022 ACK: on falling edge 11 sample filtered ps2_data; 0 = ACK good, 1 = ACK bad; go WAIT_IDLE.
REQ-023 WAIT_IDLE: when filtered clock and data are both 1, pulse done (good ACK) or ack_err (bad ACK) and return to IDLE.
REQ-024 Timeout counter shall clear on every filtered clock edge (either polarity) and on entry to RTS; in RTS, XFER, ACK, WAIT_IDLE reaching TIMEOUT_CYCLES releases both drivers, pulses timeout_err, goes IDLE.
REQ-025 tx_valid outside IDLE is ignored; tx_data changes after accept do not affect the frame.
REQ-026 Back-to-back: a new accept is possible on the cycle after done/ack_err/timeout_err.
REQ-027 done, ack_err and timeout_err are mutually exclusive, each at most once per accepted byte.

Reset
REQ-028 On rst_n low, immediately (asynchronously): state IDLE, ps2_clk_drv 0, ps2_data_drv 0, tx_ready 1, done/ack_err/timeout_err 0, filters all-ones, filtered lines 1, counters 0.
REQ-029 Reset mid-frame releases both lines at once; no pulse is generated for the aborted byte.

Configuration
REQ-030 Macro PS2_TX_ACK_CHECK_EN: defined -> ACK sampled per REQ-022, ack_err per REQ-023; undefined -> ACK value ignored, ack_err constant 0, WAIT_IDLE always ends with done.

Verification (INHIBIT_CYCLES=16, TIMEOUT_CYCLES=1000, device model clock period 200 clk)
REQ-031 tx_data=8'hED, tx_valid 1 cycle -> clk_drv high exactly 16 cycles; model captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK 0 -> single done pulse, drivers 0.
REQ-032 tx_data=8'h00 -> parity bit 1; tx_data=8'h01 -> parity bit 0; both end in done.
REQ-033 Model drives ACK 1 -> single ack_err pulse, no done (macro defined); macro undefined -> done, ack_err never 1.
REQ-034 Model stops clocking after 4th falling edge -> timeout_err pulse 1000 cycles after last edge, drivers 0, tx_ready 1.
REQ-035 rst_n low during XFER bit 3 -> drivers 0 same cycle, no pulse; next byte 8'hF4 after reset completes with done.
REQ-036 Glitches of 1-7 cycles on ps2_clk in XFER -> no extra bits; tx_valid held high during frame -> exactly one byte sent.
